lfsr_rng_gen: RTL and testbench
===============================

Name: lfsr_rng_gen

Overview:
Parametrised Fibonacci LFSR random-number generator for the hit-or-miss randomizer. Width, tap polynomial, seed and sampling stride are generics. A runtime seed load is provided, and each finished sample is delivered through a valid/ready handshake so consumers never see a half-shifted value. Sits between the game FSM (consumer) and the free-running clock domain.

Parameters:
WIDTH, 13, LFSR and output width in bits (≥3).
TAPS, 13'h100D, feedback mask; bit i=1 → state[i] in XOR feedback; TAPS[WIDTH-1] must be 1.
SEED, 13'h000F, reset/fallback state; must be nonzero.
STRIDE, 13, shifts between captured samples (≥1).

Ports:
clock  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
enable  input  1  1 = LFSR shifts this cycle; 0 = state and stride counter hold.
seed_load  input  1  load seed_in into LFSR this cycle.
seed_in  input  WIDTH  runtime seed.
rnd  output  WIDTH  captured sample; meaningful only while rnd_valid=1.
rnd_valid  output  1  sample available.
rnd_ready  input  1  consumer accepts sample when rnd_valid&rnd_ready.
missed  output  1  one-cycle pulse: stride completed while previous sample still unaccepted.

Behaviour:
- Single clock domain. Reset is asynchronous and active-high on port `reset`. All flops use reset.
- Reset values: state=SEED, count=0, rnd=0, rnd_valid=0, missed=0.
- Feedback: fb = XOR of state[i] over all i with TAPS[i]=1.
- Shift: state_next = {state[WIDTH-2:0], fb}.
- Priority per cycle is seed_load > enable > hold.
- seed_load=1: state<=seed_in, or SEED if seed_in==0 (no all-zero lockup). Also count<=0, rnd_valid<=0 (pending sample discarded), missed<=0. Ignores enable and rnd_ready.
- enable=1, seed_load=0: state<=state_next.
  - If count<STRIDE-1: count<=count+1.
  - If count==STRIDE-1: count<=0 and a capture event occurs.
- Capture event:
  - If slot free (rnd_valid=0, or rnd_valid&rnd_ready this cycle): rnd<=state_next, rnd_valid<=1.
  - Otherwise rnd and rnd_valid hold and missed<=1 for one cycle. The LFSR still advances.
- No capture and rnd_valid&rnd_ready: rnd_valid<=0; rnd holds its last value.
- enable=0: state and count frozen. The handshake still operates (a pending sample may be accepted).
- rnd, rnd_valid and missed are registered; no combinational path from inputs to outputs.
- Latency: first rnd_valid rises STRIDE enabled cycles after reset/seed_load, registered on that cycle's edge.
- rnd stays stable while rnd_valid=1 and not accepted.
- Counter width is clog2(STRIDE), minimum 1. STRIDE=1 captures every enabled cycle.
- The all-zero state is unreachable: reset and seed paths never produce 0, and nonzero states of an LFSR never map to 0.
- Reset asserted mid-operation immediately returns all outputs to reset values, regardless of handshake state.

Test Plan:
1. Defaults: reset, enable=1, rnd_ready=1 → rnd_valid first high after 13th enabled edge with rnd=13'h1FF4. Subsequent samples every 13 cycles, each a 1-cycle valid pulse.
2. Backpressure: rnd_ready=0 for 30 cycles after first capture → rnd=13'h1FF4 held, rnd_valid=1 throughout, missed pulses at captures 2 and 3. Raise rnd_ready → valid drops next edge.
3. Enable gating: toggle enable 1/0 every cycle → first capture after 26 cycles with same value 13'h1FF4; state frozen on enable=0 cycles.
4. Seed load: seed_load with seed_in=13'h000F mid-stride while a sample is pending → rnd_valid cleared next edge. The next sample is 13'h1FF4 after 13 enabled cycles.
5. Zero seed: seed_load with seed_in=0 → state becomes SEED; sequence identical to scenario 1.
6. Async reset mid-stride with rnd_valid=1 → rnd_valid, rnd, missed go to 0 without a clock edge. Alt params (WIDTH=8, TAPS=8'hB8, STRIDE=1) → 255-cycle period, no zero sample.

Source files
------------

// File: rtl/lfsr_rng_gen.sv
// lfsr_rng_gen: Fibonacci LFSR random-number generator with strided sampling and valid/ready delivery
// Ports: clock/reset (async, active-high); enable advances the LFSR and stride counter;
// seed_load/seed_in reseed the LFSR and drop any pending sample; rnd/rnd_valid/rnd_ready
// deliver one sample every STRIDE enabled cycles; missed pulses when a sample is dropped.
module lfsr_rng_gen #(
    parameter int               WIDTH  = 13,
    parameter logic [WIDTH-1:0] TAPS   = 13'h100D,
    parameter logic [WIDTH-1:0] SEED   = 13'h000F,
    parameter int               STRIDE = 13
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_in,
    output logic [WIDTH-1:0] rnd,
    output logic             rnd_valid,
    input  logic             rnd_ready,
    output logic             missed
);
    localparam int CW = (STRIDE > 1) ? $clog2(STRIDE) : 1;
    localparam logic [CW-1:0] LAST = CW'(STRIDE - 1);
    logic [WIDTH-1:0] state_q, state_d, shifted, rnd_q, rnd_d;
    logic [CW-1:0] count_q, count_d;
    logic valid_q, valid_d, missed_q, missed_d;
    logic accept, capture;
    always_comb begin
        shifted = {state_q[WIDTH-2:0], ^(state_q & TAPS)};
        accept = valid_q & rnd_ready;
        capture = ~seed_load & enable & (count_q == LAST);
        // A zero seed would lock the LFSR, so it falls back to SEED
        state_d = seed_load ? ((seed_in == '0) ? SEED : seed_in) : enable ? shifted : state_q;
        count_d = (seed_load | capture) ? '0 : enable ? count_q + 1'b1 : count_q;
        rnd_d = (capture & (~valid_q | accept)) ? shifted : rnd_q;
        // A capture always leaves a sample pending: either the new one or the unaccepted old one
        valid_d = ~seed_load & (capture | (valid_q & ~accept));
        missed_d = capture & valid_q & ~accept;
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= SEED;
            count_q <= '0;
            rnd_q <= '0;
            valid_q <= 1'b0;
            missed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            rnd_q <= rnd_d;
            valid_q <= valid_d;
            missed_q <= missed_d;
        end
    end
    assign rnd = rnd_q;
    assign rnd_valid = valid_q;
    assign missed = missed_q;
endmodule

// File: tb/tb_lfsr_rng_gen.sv
// tb_lfsr_rng_gen: randomized and directed checks of lfsr_rng_gen against a sample-level reference model
module tb_lfsr_rng_gen;
    logic clock = 1'b0;
    logic reset = 1'b0;
    logic en = 1'b0, sl = 1'b0, rdy = 1'b0;
    logic [12:0] sin = '0;
    logic [12:0] rnd;
    logic valid, missed;
    logic en2 = 1'b0, sl2 = 1'b0, rdy2 = 1'b0;
    logic [7:0] sin2 = '0;
    logic [7:0] rnd2;
    logic valid2, missed2;
    int checks = 0, failures = 0;
    logic [12:0] m_state, e_rnd;
    logic e_valid, e_missed;
    int m_shifts;

    always #5 clock = ~clock;

    lfsr_rng_gen dut (
        .clock(clock), .reset(reset), .enable(en), .seed_load(sl), .seed_in(sin),
        .rnd(rnd), .rnd_valid(valid), .rnd_ready(rdy), .missed(missed)
    );

    lfsr_rng_gen #(.WIDTH(8), .TAPS(8'hB8), .SEED(8'h0F), .STRIDE(1)) dut2 (
        .clock(clock), .reset(reset), .enable(en2), .seed_load(sl2), .seed_in(sin2),
        .rnd(rnd2), .rnd_valid(valid2), .rnd_ready(rdy2), .missed(missed2)
    );

    function automatic logic [12:0] adv13(input logic [12:0] s);
        int p = $countones(s & 13'h100D) % 2;
        return 13'((int'(s) * 2) % 8192 + p);
    endfunction

    function automatic logic [7:0] adv8(input logic [7:0] s);
        int p = $countones(s & 8'hB8) % 2;
        return 8'((int'(s) * 2) % 256 + p);
    endfunction

    task automatic model_reset();
        m_state = 13'h000F;
        m_shifts = 0;
        e_rnd = '0;
        e_valid = 1'b0;
        e_missed = 1'b0;
    endtask

    // Sample-level view: every 13th shift since the last (re)seed produces a sample
    task automatic model_edge();
        bit take;
        take = e_valid && rdy;
        e_missed = 1'b0;
        if (sl) begin
            m_state = (sin == 0) ? 13'h000F : sin;
            m_shifts = 0;
            e_valid = 1'b0;
        end else begin
            if (en) begin
                m_state = adv13(m_state);
                m_shifts++;
            end
            if (en && m_shifts % 13 == 0) begin
                if (!e_valid || take) begin
                    e_rnd = m_state;
                    e_valid = 1'b1;
                end else e_missed = 1'b1;
            end else if (take) e_valid = 1'b0;
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        en = 0; sl = 0; rdy = 0; sin = 0; en2 = 0; sl2 = 0; rdy2 = 0; sin2 = 0;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        checks++;
        if (rnd !== 13'h0 || valid !== 1'b0 || missed !== 1'b0 || valid2 !== 1'b0) begin
            failures++;
            $display("FAIL reset: rnd=%h valid=%b missed=%b valid2=%b, want 0 0 0 0", rnd, valid, missed, valid2);
        end
        do_reset();
        checks++;
        if (rnd !== 13'h0 || valid !== 1'b0 || missed !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: rnd=%h valid=%b missed=%b, want 0 0 0", rnd, valid, missed);
        end
    endtask

    task automatic test_defaults();
        do_reset();
        en = 1; rdy = 1;
        for (int i = 1; i <= 52; i++) begin
            cyc();
            checks++;
            if (valid !== e_valid || missed !== e_missed || (e_valid && rnd !== e_rnd)) begin
                failures++;
                $display("FAIL defaults cyc%0d: valid=%b missed=%b rnd=%h, want %b %b %h", i, valid, missed, rnd, e_valid, e_missed, e_rnd);
            end
            if (i == 13) begin
                checks++;
                if (valid !== 1'b1 || rnd !== 13'h1FF4) begin
                    failures++;
                    $display("FAIL defaults_first: valid=%b rnd=%h, want 1 1ff4", valid, rnd);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        en = 1; rdy = 1;
        repeat (13) cyc();
        rdy = 0;
        for (int j = 1; j <= 30; j++) begin
            cyc();
            checks++;
            if (valid !== 1'b1 || rnd !== 13'h1FF4 || missed !== (j == 13 || j == 26)) begin
                failures++;
                $display("FAIL backpressure cyc%0d: valid=%b rnd=%h missed=%b, want 1 1ff4 %b", j, valid, rnd, missed, (j == 13 || j == 26));
            end
        end
        rdy = 1;
        cyc();
        checks++;
        if (valid !== 1'b0 || missed !== 1'b0) begin
            failures++;
            $display("FAIL backpressure_release: valid=%b missed=%b, want 0 0", valid, missed);
        end
    endtask

    task automatic test_enable_gating();
        int first = -1;
        do_reset();
        rdy = 1;
        for (int i = 1; i <= 30; i++) begin
            en = (i % 2 == 0);
            cyc();
            checks++;
            if (valid !== e_valid || missed !== e_missed || (e_valid && rnd !== e_rnd)) begin
                failures++;
                $display("FAIL gating cyc%0d: valid=%b missed=%b rnd=%h, want %b %b %h", i, valid, missed, rnd, e_valid, e_missed, e_rnd);
            end
            if (valid === 1'b1 && first < 0) first = i;
        end
        checks++;
        if (first != 26) begin
            failures++;
            $display("FAIL gating_latency: first valid at cycle %0d, want 26", first);
        end
    endtask

    task automatic test_seed_load();
        do_reset();
        en = 1; rdy = 0;
        repeat (18) cyc();
        sl = 1; sin = 13'h000F; rdy = 1;
        cyc();
        checks++;
        if (valid !== 1'b0 || missed !== 1'b0) begin
            failures++;
            $display("FAIL seed_load_clear: valid=%b missed=%b, want 0 0", valid, missed);
        end
        sl = 0;
        for (int i = 1; i <= 13; i++) begin
            cyc();
            checks++;
            if (valid !== e_valid || missed !== e_missed || (e_valid && rnd !== e_rnd)) begin
                failures++;
                $display("FAIL seed_load cyc%0d: valid=%b missed=%b rnd=%h, want %b %b %h", i, valid, missed, rnd, e_valid, e_missed, e_rnd);
            end
        end
        checks++;
        if (valid !== 1'b1 || rnd !== 13'h1FF4) begin
            failures++;
            $display("FAIL seed_load_sample: valid=%b rnd=%h, want 1 1ff4", valid, rnd);
        end
    endtask

    task automatic test_zero_seed();
        en = 1; rdy = 1;
        repeat (4) cyc();
        sl = 1; sin = 13'h0;
        cyc();
        sl = 0;
        for (int i = 1; i <= 26; i++) begin
            cyc();
            checks++;
            if (valid !== e_valid || missed !== e_missed || (e_valid && rnd !== e_rnd)) begin
                failures++;
                $display("FAIL zero_seed cyc%0d: valid=%b missed=%b rnd=%h, want %b %b %h", i, valid, missed, rnd, e_valid, e_missed, e_rnd);
            end
            if (i == 13) begin
                checks++;
                if (valid !== 1'b1 || rnd !== 13'h1FF4) begin
                    failures++;
                    $display("FAIL zero_seed_sample: valid=%b rnd=%h, want 1 1ff4", valid, rnd);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        en = 1; rdy = 0;
        repeat (26) cyc();
        checks++;
        if (valid !== 1'b1 || missed !== 1'b1 || rnd !== 13'h1FF4) begin
            failures++;
            $display("FAIL async_pre: valid=%b missed=%b rnd=%h, want 1 1 1ff4", valid, missed, rnd);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (valid !== 1'b0 || missed !== 1'b0 || rnd !== 13'h0) begin
            failures++;
            $display("FAIL async_reset: valid=%b missed=%b rnd=%h, want 0 0 0", valid, missed, rnd);
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_alt_params();
        logic [7:0] m2, first2;
        bit seen [256];
        int uniq = 0;
        do_reset();
        en2 = 1; rdy2 = 1;
        m2 = 8'h0F;
        first2 = '0;
        for (int i = 1; i <= 256; i++) begin
            cyc();
            m2 = adv8(m2);
            checks++;
            if (valid2 !== 1'b1 || missed2 !== 1'b0 || rnd2 !== m2 || rnd2 == 8'h0) begin
                failures++;
                $display("FAIL alt cyc%0d: valid=%b missed=%b rnd=%h, want 1 0 %h", i, valid2, missed2, rnd2, m2);
            end
            if (i == 1) first2 = rnd2;
            if (i <= 255 && !seen[rnd2]) begin
                seen[rnd2] = 1'b1;
                uniq++;
            end
        end
        checks++;
        if (uniq != 255 || rnd2 !== first2) begin
            failures++;
            $display("FAIL alt_period: distinct=%0d wrap=%h, want 255 %h", uniq, rnd2, first2);
        end
        en2 = 0;
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 1; i <= 2000; i++) begin
            en = ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 2) == 0);
            sl = ($urandom_range(0, 99) == 0);
            sin = ($urandom_range(0, 3) == 0) ? 13'h0 : 13'($urandom);
            cyc();
            checks++;
            if (valid !== e_valid || missed !== e_missed || (e_valid && rnd !== e_rnd)) begin
                failures++;
                $display("FAIL random cyc%0d: valid=%b missed=%b rnd=%h, want %b %b %h", i, valid, missed, rnd, e_valid, e_missed, e_rnd);
            end
        end
        sl = 0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_defaults();
        test_backpressure();
        test_enable_gating();
        test_seed_load();
        test_zero_seed();
        test_async_reset();
        test_alt_params();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
